// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes a p_N-bit result word as ceil(p_N/8) 8N1 bytes,
// least-significant byte first, on uart_txd. A one-cycle start request in
// IDLE latches the word; done pulses for one cycle after the final stop bit.
module uart_result_tx #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 57600,
    parameter int p_N            = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [p_N-1:0] data,
    output logic           busy,
    output logic           done,
    output logic           uart_txd
);

    localparam int DIV = clk_freq / uart_baud_rate;
    localparam int NB  = (p_N + 7) / 8;
    localparam int SW  = NB * 8;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP      = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_cnt_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nxt;
    logic [BW-1:0] byte_idx;
    logic [BW-1:0] byte_idx_nxt;
    logic [SW-1:0] shreg;
    logic          load;
    logic          shift;
    logic          bit_end;
    logic          txd_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    // A bit period ends when the baud counter reaches its last count
    assign bit_end = (baud_cnt == BAUD_LAST);

    // State register: FSM, counters and the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            uart_txd <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            uart_txd <= txd_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Word shifter: the LSB is always the bit currently on the line, so the
    // whole word drains LSB first across byte boundaries; padding is zero
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= SW'(data);
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    // Next-state logic: frame sequencing and baud/bit/byte counters
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        load         = 1'b0;
        shift        = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                if (start) begin
                    state_nxt    = START_BIT;
                    bit_idx_nxt  = '0;
                    byte_idx_nxt = '0;
                    load         = 1'b1;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == BYTE_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = START_BIT;
                        byte_idx_nxt = byte_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        end
    end

    // Output logic: values the output registers take on the next edge
    always_comb begin
        txd_nxt  = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && bit_end && (byte_idx == BYTE_LAST);
        case (state_nxt)
            START_BIT: txd_nxt = 1'b0;
            // When a shift happens this edge, the next bit is shreg[1]
            DATA:      txd_nxt = shift ? shreg[1] : shreg[0];
            default:   txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx at DIV=10: one 16-bit instance and one 12-bit
// instance. Line monitors decode 8N1 frames into received-byte queues;
// expected bytes are queued when each word is launched.
module tb_uart_result_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16;
    logic        start12;
    logic [15:0] data16;
    logic [11:0] data12;
    logic        busy16, done16, txd16;
    logic        busy12, done12, txd12;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] exp16_q[$];
    logic [8:0] exp12_q[$];
    logic [8:0] got16_q[$];
    logic [8:0] got12_q[$];
    int         rd16 = 0;
    int         rd12 = 0;

    always #5 clk = ~clk;

    uart_result_tx #(.clk_freq(1000), .uart_baud_rate(100), .p_N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .data(data16),
        .busy(busy16), .done(done16), .uart_txd(txd16)
    );

    uart_result_tx #(.clk_freq(1000), .uart_baud_rate(100), .p_N(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .data(data12),
        .busy(busy12), .done(done12), .uart_txd(txd12)
    );

    // Frame decoder for the 16-bit instance: samples mid-bit, pushes
    // {framing_ok, byte}; abandons a frame if busy drops mid-frame.
    logic       m16_act  = 1'b0;
    int         m16_cnt  = 0;
    logic       m16_ok   = 1'b1;
    logic [7:0] m16_byte = 8'h00;
    always @(negedge clk) begin
        if (!m16_act) begin
            if (busy16 === 1'b1 && txd16 === 1'b0) begin
                m16_act <= 1'b1;
                m16_cnt <= 1;
                m16_ok  <= 1'b1;
            end
        end else if (busy16 !== 1'b1) begin
            m16_act <= 1'b0;
        end else begin
            m16_cnt <= m16_cnt + 1;
            if (m16_cnt == 5 && txd16 !== 1'b0) m16_ok <= 1'b0;
            if (m16_cnt >= 15 && m16_cnt <= 85 && (m16_cnt % 10) == 5)
                m16_byte <= {txd16, m16_byte[7:1]};
            if (m16_cnt == 95) begin
                got16_q.push_back({m16_ok & (txd16 === 1'b1), m16_byte});
                m16_act <= 1'b0;
            end
        end
    end

    // Frame decoder for the 12-bit instance
    logic       m12_act  = 1'b0;
    int         m12_cnt  = 0;
    logic       m12_ok   = 1'b1;
    logic [7:0] m12_byte = 8'h00;
    always @(negedge clk) begin
        if (!m12_act) begin
            if (busy12 === 1'b1 && txd12 === 1'b0) begin
                m12_act <= 1'b1;
                m12_cnt <= 1;
                m12_ok  <= 1'b1;
            end
        end else if (busy12 !== 1'b1) begin
            m12_act <= 1'b0;
        end else begin
            m12_cnt <= m12_cnt + 1;
            if (m12_cnt == 5 && txd12 !== 1'b0) m12_ok <= 1'b0;
            if (m12_cnt >= 15 && m12_cnt <= 85 && (m12_cnt % 10) == 5)
                m12_byte <= {txd12, m12_byte[7:1]};
            if (m12_cnt == 95) begin
                got12_q.push_back({m12_ok & (txd12 === 1'b1), m12_byte});
                m12_act <= 1'b0;
            end
        end
    end

    task automatic test_reset;
        rst     = 1'b1;
        start16 = 1'b1;
        start12 = 1'b1;
        data16  = 16'hFFFF;
        data12  = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({txd16, busy16, done16} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_out16: got txd/busy/done=%b required 100", {txd16, busy16, done16});
            end
            vectors++;
            if ({txd12, busy12, done12} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_out12: got txd/busy/done=%b required 100", {txd12, busy12, done12});
            end
        end
        rst     = 1'b0;
        start16 = 1'b0;
        start12 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy16, busy12} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_frame: got busy16/busy12=%b required 00", {busy16, busy12});
        end
        vectors++;
        if (got16_q.size() + got12_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_bytes: got %0d bytes required 0", got16_q.size() + got12_q.size());
        end
    endtask

    task automatic test_basic;
        int busy_cnt = 0, done_cnt = 0, first_busy = 0, done_at = 0;
        logic txd_first = 1'b1, txd_done = 1'b0;
        logic [8:0] e;
        data16  = 16'hA55A;
        start16 = 1'b1;
        exp16_q.push_back({1'b1, 8'h5A});
        exp16_q.push_back({1'b1, 8'hA5});
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start16   = 1'b0;
                txd_first = txd16;
            end
            if (busy16 === 1'b1) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = i;
            end
            if (done16 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at  = i;
                    txd_done = txd16;
                end
            end
        end
        vectors++;
        if (txd_first !== 1'b0 || first_busy != 1) begin
            miscompares++;
            $display("FAIL basic_start: got txd=%b first_busy=%0d required txd=0 first_busy=1", txd_first, first_busy);
        end
        vectors++;
        if (busy_cnt != 200) begin
            miscompares++;
            $display("FAIL basic_busy_len: got %0d required 200", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1 || done_at != 201 || txd_done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: got count=%0d at=%0d txd=%b required count=1 at=201 txd=1", done_cnt, done_at, txd_done);
        end
        while (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            vectors++;
            if (rd16 >= got16_q.size()) begin
                miscompares++;
                $display("FAIL basic_byte: got nothing required %h", e);
            end else begin
                if (got16_q[rd16] !== e) begin
                    miscompares++;
                    $display("FAIL basic_byte: got %h required %h", got16_q[rd16], e);
                end
                rd16++;
            end
        end
        vectors++;
        if (rd16 != got16_q.size()) begin
            miscompares++;
            $display("FAIL basic_extra_bytes: got %0d extra required 0", got16_q.size() - rd16);
            rd16 = got16_q.size();
        end
    endtask

    task automatic test_ignored_start;
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        logic [8:0] e;
        data16  = 16'hA55A;
        start16 = 1'b1;
        exp16_q.push_back({1'b1, 8'h5A});
        exp16_q.push_back({1'b1, 8'hA5});
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (i == 1) start16 = 1'b0;
            if (i == 50) begin
                start16 = 1'b1;
                data16  = 16'h1234;
            end
            if (i == 51) start16 = 1'b0;
            if (busy16 === 1'b1) busy_cnt++;
            if (done16 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        vectors++;
        if (busy_cnt != 200) begin
            miscompares++;
            $display("FAIL ignored_busy_len: got %0d required 200", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1 || done_at != 201) begin
            miscompares++;
            $display("FAIL ignored_done: got count=%0d at=%0d required count=1 at=201", done_cnt, done_at);
        end
        while (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            vectors++;
            if (rd16 >= got16_q.size()) begin
                miscompares++;
                $display("FAIL ignored_byte: got nothing required %h", e);
            end else begin
                if (got16_q[rd16] !== e) begin
                    miscompares++;
                    $display("FAIL ignored_byte: got %h required %h", got16_q[rd16], e);
                end
                rd16++;
            end
        end
        vectors++;
        if (rd16 != got16_q.size()) begin
            miscompares++;
            $display("FAIL ignored_extra_bytes: got %0d extra required 0", got16_q.size() - rd16);
            rd16 = got16_q.size();
        end
    endtask

    task automatic test_back_to_back;
        int busy_cnt = 0, done_cnt = 0, first_busy = 0, last_busy = 0;
        int d1 = 0, d2 = 0, gap;
        logic txd_201 = 1'b0, txd_202 = 1'b1;
        logic [8:0] e;
        data16  = 16'h00FF;
        start16 = 1'b1;
        exp16_q.push_back({1'b1, 8'hFF});
        exp16_q.push_back({1'b1, 8'h00});
        for (int i = 1; i <= 460; i++) begin
            @(negedge clk);
            if (i == 1) begin
                data16 = 16'hFF00;
                exp16_q.push_back({1'b1, 8'h00});
                exp16_q.push_back({1'b1, 8'hFF});
            end
            if (i == 201) txd_201 = txd16;
            if (i == 202) begin
                txd_202 = txd16;
                start16 = 1'b0;
            end
            if (busy16 === 1'b1) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = i;
                last_busy = i;
            end
            if (done16 === 1'b1) begin
                done_cnt++;
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
            end
        end
        gap = (last_busy - first_busy + 1) - busy_cnt;
        vectors++;
        if (busy_cnt != 400 || gap != 1) begin
            miscompares++;
            $display("FAIL b2b_busy: got busy=%0d gap=%0d required busy=400 gap=1", busy_cnt, gap);
        end
        vectors++;
        if (done_cnt != 2 || d1 != 201 || d2 != 402) begin
            miscompares++;
            $display("FAIL b2b_done: got count=%0d at %0d,%0d required count=2 at 201,402", done_cnt, d1, d2);
        end
        vectors++;
        if (txd_201 !== 1'b1 || txd_202 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_line: got txd201=%b txd202=%b required 1,0", txd_201, txd_202);
        end
        while (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            vectors++;
            if (rd16 >= got16_q.size()) begin
                miscompares++;
                $display("FAIL b2b_byte: got nothing required %h", e);
            end else begin
                if (got16_q[rd16] !== e) begin
                    miscompares++;
                    $display("FAIL b2b_byte: got %h required %h", got16_q[rd16], e);
                end
                rd16++;
            end
        end
        vectors++;
        if (rd16 != got16_q.size()) begin
            miscompares++;
            $display("FAIL b2b_extra_bytes: got %0d extra required 0", got16_q.size() - rd16);
            rd16 = got16_q.size();
        end
    endtask

    task automatic test_reset_mid;
        int busy_cnt = 0, done_cnt = 0, done_at = 0, stray_done = 0;
        logic [8:0] e;
        data16  = 16'hBEEF;
        start16 = 1'b1;
        exp16_q.push_back({1'b1, 8'hEF});
        // Byte 1 data bit 0 (a 0 bit of 0xBE) spans cycles 111..120
        for (int i = 1; i <= 115; i++) begin
            @(negedge clk);
            if (i == 1) start16 = 1'b0;
            if (done16 === 1'b1) stray_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({txd16, busy16, done16} !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst_out: got txd/busy/done=%b required 100", {txd16, busy16, done16});
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done16 === 1'b1 || busy16 !== 1'b0) stray_done++;
        end
        vectors++;
        if (stray_done != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got %0d busy/done cycles required 0", stray_done);
        end
        data16  = 16'h0001;
        start16 = 1'b1;
        exp16_q.push_back({1'b1, 8'h01});
        exp16_q.push_back({1'b1, 8'h00});
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (i == 1) start16 = 1'b0;
            if (busy16 === 1'b1) busy_cnt++;
            if (done16 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        vectors++;
        if (busy_cnt != 200 || done_cnt != 1 || done_at != 201) begin
            miscompares++;
            $display("FAIL midrst_resume: got busy=%0d done=%0d at=%0d required 200,1,201", busy_cnt, done_cnt, done_at);
        end
        while (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            vectors++;
            if (rd16 >= got16_q.size()) begin
                miscompares++;
                $display("FAIL midrst_byte: got nothing required %h", e);
            end else begin
                if (got16_q[rd16] !== e) begin
                    miscompares++;
                    $display("FAIL midrst_byte: got %h required %h", got16_q[rd16], e);
                end
                rd16++;
            end
        end
        vectors++;
        if (rd16 != got16_q.size()) begin
            miscompares++;
            $display("FAIL midrst_extra_bytes: got %0d extra required 0", got16_q.size() - rd16);
            rd16 = got16_q.size();
        end
    endtask

    task automatic test_padding;
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        logic [8:0] e;
        data12  = 12'hABC;
        start12 = 1'b1;
        exp12_q.push_back({1'b1, 8'hBC});
        exp12_q.push_back({1'b1, 8'h0A});
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (i == 1) start12 = 1'b0;
            if (busy12 === 1'b1) busy_cnt++;
            if (done12 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        vectors++;
        if (busy_cnt != 200) begin
            miscompares++;
            $display("FAIL pad_busy_len: got %0d required 200", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1 || done_at != 201) begin
            miscompares++;
            $display("FAIL pad_done: got count=%0d at=%0d required count=1 at=201", done_cnt, done_at);
        end
        while (exp12_q.size() > 0) begin
            e = exp12_q.pop_front();
            vectors++;
            if (rd12 >= got12_q.size()) begin
                miscompares++;
                $display("FAIL pad_byte: got nothing required %h", e);
            end else begin
                if (got12_q[rd12] !== e) begin
                    miscompares++;
                    $display("FAIL pad_byte: got %h required %h", got12_q[rd12], e);
                end
                rd12++;
            end
        end
        vectors++;
        if (rd12 != got12_q.size()) begin
            miscompares++;
            $display("FAIL pad_extra_bytes: got %0d extra required 0", got12_q.size() - rd12);
            rd12 = got12_q.size();
        end
    endtask

    initial begin
        rst     = 1'b1;
        start16 = 1'b0;
        start12 = 1'b0;
        data16  = 16'h0000;
        data12  = 12'h000;
        test_reset;
        test_basic;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_padding;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
